// File: rtl/audio_i2s_pkg.sv
// Shared constants for the I2S transmitter: slot/frame geometry and counter sizing.
package audio_i2s_pkg;

   localparam int unsigned SLOT_W     = 16;
   localparam int unsigned FRAME_BITS = 32;
   localparam int unsigned SLOT_IDX_W = $clog2(FRAME_BITS);

   function automatic int unsigned cnt_width(input int unsigned sclk_div);
      return $clog2(FRAME_BITS * sclk_div);
   endfunction

endpackage

// File: rtl/audio_i2s_tx.sv
// Fixed-format I2S transmitter: mono sample sent in both slots, all clocks from one frame counter.
// Define AUDIO_I2S_OFFSET_BINARY_EN to accept offset-binary input (MSB inverted on load).
module audio_i2s_tx
   import audio_i2s_pkg::*;
#(
   parameter int unsigned P_mclk_div = 2,
   parameter int unsigned P_sclk_div = 16
) (
   input  logic              I_clock,
   input  logic              I_reset,
   input  logic [SLOT_W-1:0] I_data,
   output logic              O_mclk,
   output logic              O_wclk,
   output logic              O_sclk,
   output logic              O_data
);

   localparam int unsigned CNT_W  = cnt_width(P_sclk_div);
   localparam int unsigned SCLK_W = $clog2(P_sclk_div);
   localparam int unsigned MCLK_W = $clog2(P_mclk_div);
   localparam logic [CNT_W-1:0] LOAD_AT = CNT_W'(P_sclk_div - 1);

   logic [CNT_W-1:0]      r_cnt;
   logic [SLOT_W-1:0]     r_hold;
   logic                  r_mclk;
   logic                  r_wclk;
   logic                  r_sclk;
   logic                  r_data;

   logic [SLOT_IDX_W-1:0] w_slot;
   logic [SLOT_IDX_W-1:0] w_bit;
   logic [SLOT_W-1:0]     w_load;
   logic                  w_mclk;
   logic                  w_sclk;
   logic                  w_wclk;
   logic                  w_data;

   // Dividers are powers of two, so the phase tests reduce to single counter bits.
   assign w_slot = r_cnt[CNT_W-1 -: SLOT_IDX_W];
   assign w_bit  = w_slot - SLOT_IDX_W'(1);
   assign w_mclk = r_cnt[MCLK_W-1];
   assign w_sclk = r_cnt[SCLK_W-1];
   assign w_wclk = w_bit[SLOT_IDX_W-1];
   // 15 - (k mod 16) is the bitwise complement of the low four index bits.
   assign w_data = r_hold[~w_bit[SLOT_IDX_W-2:0]];

`ifdef AUDIO_I2S_OFFSET_BINARY_EN
   assign w_load = {~I_data[SLOT_W-1], I_data[SLOT_W-2:0]};
`else
   assign w_load = I_data;
`endif

   always_ff @(posedge I_clock) begin
      if (!I_reset) begin
         r_cnt  <= '0;
         r_hold <= '0;
         r_mclk <= 1'b0;
         r_wclk <= 1'b0;
         r_sclk <= 1'b0;
         r_data <= 1'b0;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         if (r_cnt == LOAD_AT) begin
            r_hold <= w_load;
         end
         r_mclk <= w_mclk;
         r_wclk <= w_wclk;
         r_sclk <= w_sclk;
         r_data <= w_data;
      end
   end

   assign O_mclk = r_mclk;
   assign O_wclk = r_wclk;
   assign O_sclk = r_sclk;
   assign O_data = r_data;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: words captured on SCLK rising edges, clock periods measured.
// Honours AUDIO_I2S_OFFSET_BINARY_EN for the expected word encoding.
module tb_audio_i2s_tx;

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [15:0] i_data = '0;
   logic        o_mclk, o_wclk, o_sclk, o_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] sb_q[$];

   always #5 clk = ~clk;

   audio_i2s_tx #(
      .P_mclk_div(2),
      .P_sclk_div(16)
   ) u_dut (
      .I_clock(clk),
      .I_reset(i_reset),
      .I_data (i_data),
      .O_mclk (o_mclk),
      .O_wclk (o_wclk),
      .O_sclk (o_sclk),
      .O_data (o_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [15:0] d);
`ifdef AUDIO_I2S_OFFSET_BINARY_EN
      return d ^ 16'h8000;
`else
      return d;
`endif
   endfunction

   task automatic check_outs(input string tag, input logic [3:0] exp);
      check_eq({tag, "_mclk"}, 32'(o_mclk), 32'(exp[3]));
      check_eq({tag, "_wclk"}, 32'(o_wclk), 32'(exp[2]));
      check_eq({tag, "_sclk"}, 32'(o_sclk), 32'(exp[1]));
      check_eq({tag, "_data"}, 32'(o_data), 32'(exp[0]));
   endtask

   // ---------------- monitor ----------------
   logic        dut_live = 1'b0;
   int          cyc = 0;
   logic        m_prev_mclk = 1'b0, m_prev_sclk = 1'b0, m_prev_wclk = 1'b1;
   logic        m_slot_wclk = 1'b0;
   logic [15:0] m_shreg = '0;
   int          m_nbits = 0;
   // 0 mclk period, 1 sclk period, 2 wclk period, 3 wclk high, 4 wclk low
   int          m_last[4];
   logic [3:0]  m_seen = '0;
   int          mn[5] = '{default: 1000000};
   int          mx[5] = '{default: 0};

   always @(posedge clk) dut_live <= i_reset;

   task automatic note(input int idx, input int d);
      if (d < mn[idx]) mn[idx] = d;
      if (d > mx[idx]) mx[idx] = d;
   endtask

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!dut_live) begin
         m_prev_mclk <= 1'b0;
         m_prev_sclk <= 1'b0;
         m_prev_wclk <= 1'b1;
         m_seen      <= '0;
         m_nbits     <= 0;
      end else begin
         m_prev_mclk <= o_mclk;
         m_prev_sclk <= o_sclk;
         m_prev_wclk <= o_wclk;
         if (o_mclk && !m_prev_mclk) begin
            if (m_seen[0]) note(0, cyc - m_last[0]);
            m_last[0] <= cyc;
            m_seen[0] <= 1'b1;
         end
         if (o_wclk && !m_prev_wclk) begin
            if (m_seen[2]) note(2, cyc - m_last[2]);
            if (m_seen[3]) note(4, cyc - m_last[3]);
            m_last[2] <= cyc;
            m_seen[2] <= 1'b1;
         end
         if (!o_wclk && m_prev_wclk) begin
            if (m_seen[2]) note(3, cyc - m_last[2]);
            m_last[3] <= cyc;
            m_seen[3] <= 1'b1;
         end
         if (o_sclk && !m_prev_sclk) begin
            if (m_seen[1]) note(1, cyc - m_last[1]);
            m_last[1] <= cyc;
            m_seen[1] <= 1'b1;
            if (m_nbits != 0 && o_wclk == m_slot_wclk) begin
               m_shreg <= {m_shreg[14:0], o_data};
               if (m_nbits == 15) begin
                  m_nbits <= 0;
                  if (sb_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
                  else check_eq(o_wclk ? "word_right" : "word_left",
                                32'({m_shreg[14:0], o_data}), 32'(sb_q.pop_front()));
               end else begin
                  m_nbits <= m_nbits + 1;
               end
            end else begin
               m_shreg     <= {15'd0, o_data};
               m_nbits     <= 1;
               m_slot_wclk <= o_wclk;
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Runs one 512-clock frame starting just before counter value 0.
   task automatic send_frame(input logic [15:0] d, input logic [15:0] d_late, input bit late,
                             input bit first);
      logic [15:0] e;
      e = exp_word(d);
      i_data = d;
      sb_q.push_back(e);
      sb_q.push_back(e);
      @(posedge clk);
      if (first) begin
         @(negedge clk);
         check_outs("first_cycle", 4'b0100);
      end
      repeat (15) @(posedge clk);
      if (first) begin
         @(negedge clk);
         check_eq("pre_msb_data", 32'(o_data), 32'd0);
      end
      @(posedge clk);
      if (first) begin
         @(negedge clk);
         check_eq("msb_data", 32'(o_data), 32'(e[15]));
         check_eq("msb_wclk", 32'(o_wclk), 32'd0);
      end
      repeat (112) @(posedge clk);
      #1;
      if (late) i_data = d_late;
      repeat (383) @(posedge clk);
      #1;
   endtask

   initial begin
      i_reset = 1'b0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check_outs("reset", 4'b0000);
      end
      @(posedge clk);
      #1 i_reset = 1'b1;

      send_frame(16'hA5C3, 16'h0000, 1'b0, 1'b1);
      send_frame(16'h1234, 16'hFFFF, 1'b1, 1'b0);
      send_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      send_frame(16'h8000, 16'h8000, 1'b0, 1'b0);
      send_frame(16'h0001, 16'h0001, 1'b0, 1'b0);

      // Abort a frame at counter value 300: only its left word completes.
      i_data = 16'h3C5A;
      sb_q.push_back(exp_word(16'h3C5A));
      repeat (300) @(posedge clk);
      #1 i_reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_outs("mid_reset", 4'b0000);
      repeat (2) @(posedge clk);
      #1 i_reset = 1'b1;

      send_frame(16'h7FFF, 16'h0000, 1'b0, 1'b1);
      repeat (24) @(posedge clk);
      @(negedge clk);

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      check_eq("mclk_period_min", 32'(mn[0]), 32'd2);
      check_eq("mclk_period_max", 32'(mx[0]), 32'd2);
      check_eq("sclk_period_min", 32'(mn[1]), 32'd16);
      check_eq("sclk_period_max", 32'(mx[1]), 32'd16);
      check_eq("wclk_period_min", 32'(mn[2]), 32'd512);
      check_eq("wclk_period_max", 32'(mx[2]), 32'd512);
      check_eq("wclk_high_min", 32'(mn[3]), 32'd256);
      check_eq("wclk_high_max", 32'(mx[3]), 32'd256);
      check_eq("wclk_low_min", 32'(mn[4]), 32'd256);
      check_eq("wclk_low_max", 32'(mx[4]), 32'd256);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
